fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Arbitration and sequencing controller that shares one FPU add/sub core between N_REQ requesters. Each requester presents an operand pair (32-bit team float: sign [31], exponent [30:25] with bias 31, mantissa [24:0]) on a valid/ready handshake. The arbiter grants round-robin, issues a one-cycle start to the core and waits for done, guarding with a timeout. It returns the result to the owning requester on a response handshake. It sits between the requester ports and the FPU core, and is the only driver of the core's operand and start inputs.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- TIMEOUT, default 16: maximum cycles spent in WAIT before the operation is abandoned, 2..255.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, at most one bit high.
- req_op_a  in  32*N_REQ  operand A, slice [32*i+31:32*i] for requester i.
- req_op_b  in  32*N_REQ  operand B, same slicing.
- fpu_start  out  1  one-cycle start pulse to the core.
- fpu_op_a  out  32  registered operand A to the core.
- fpu_op_b  out  32  registered operand B to the core.
- fpu_done  in  1  core result valid, single-cycle pulse.
- fpu_data  in  32  core result, valid with fpu_done.
- fpu_status  in  4  core status, valid with fpu_done.
- resp_valid  out  N_REQ  one-hot response valid to the owner.
- resp_data  out  32  result for the owner.
- resp_status  out  4  status for the owner.
- resp_ready  in  1  response accepted (shared; qualified by resp_valid).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND. Reset state is IDLE.
- **IDLE**
  - If any req_valid is set, grant g = first set bit searching upward from rr_ptr, wrapping.
  - req_ready[g]=1 combinationally in the same cycle.
  - On the edge: capture req_op_a/b slice g into fpu_op_a/b; owner<=g; rr_ptr<=(g+1) mod N_REQ; go to ISSUE.
  - With no valid, stay in IDLE; all req_ready=0.
- **ISSUE**
  - fpu_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - If fpu_done=1: capture fpu_data into resp_data and fpu_status into resp_status; go to RESPOND.
  - Else if counter==TIMEOUT-1: resp_data<=0, resp_status<=4'b1111; go to RESPOND.
  - If fpu_done coincides with the timeout cycle, done wins.
- **RESPOND**
  - resp_valid[owner]=1; resp_data and resp_status held stable.
  - On resp_ready=1, go to IDLE.
  - Back-pressure is unlimited; no new grant is made meanwhile.
- fpu_done is sampled only in WAIT. Done in any other state, including a late done after a timeout, is ignored.
- req_ready is never asserted outside IDLE. A requester holding valid simply waits.
- rr_ptr resets to 0 and advances only on a grant.
- Counter width is clog2(TIMEOUT)+1; it never wraps, because WAIT exits at TIMEOUT-1.

## Timing
- Reset values:
  - req_ready=0, fpu_start=0, fpu_op_a=0, fpu_op_b=0.
  - resp_valid=0, resp_data=0, resp_status=0.
  - rr_ptr=0, owner=0, counter=0.
- Cycle 0 (IDLE): accept.
- Cycle 1: fpu_start high.
- Cycle 2 earliest: fpu_done sampled.
- Cycle 3: resp_valid high.
- Minimum accept-to-response latency is 3 cycles. Throughput is one operation per 4 cycles minimum, with back-to-back requests and resp_ready held high.
- Timeout path: resp_valid asserts TIMEOUT+2 cycles after accept.
- fpu_op_a/b hold from ISSUE until the next grant.
- Reset deasserted mid-operation: all state is lost immediately and the FSM returns to IDLE. No response is issued for the in-flight request, and no spurious fpu_start is generated.

## Test plan
- **Single request**
  - Stimulus: requester 0 sends A=0x3E000000 (1.0) and B=0x3E000000. The stub core returns done 1 cycle after start, with fpu_data=0x40000000 and status 0.
  - Required: req_ready[0] high at cycle 0, fpu_start at cycle 1, resp_valid=4'b0001 with data 0x40000000 at cycle 3.
- **Round-robin fairness**
  - Stimulus: all 4 requesters hold valid continuously, with resp_ready=1.
  - Required: grants in order 0,1,2,3,0. Each grant is exactly 4 cycles after the previous one.
- **Pointer wrap**
  - Stimulus: only requesters 3 and 1 valid, starting from rr_ptr=0.
  - Required: grant 1, then 3, then 1. rr_ptr wraps 3→0.
- **Timeout**
  - Stimulus: TIMEOUT=16 and the core never asserts done.
  - Required: resp_status=4'b1111 and resp_data=0 at cycle 18. A done injected 5 cycles later is ignored, and the next grant proceeds normally.
- **Back-pressure**
  - Stimulus: resp_ready held low for 10 cycles while requester 2 waits.
  - Required: resp_valid and data stay stable, and req_ready stays 0. Requester 2 is granted the cycle after resp_ready rises and the FSM returns to IDLE.
- **Reset mid-operation**
  - Stimulus: reset asserted low during WAIT.
  - Required: all outputs go to their reset values immediately. After release there is no resp_valid and no fpu_start until a new request arrives.

Source files
------------

// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: bundle of every handshake and data signal around fpu_arbiter.
//
// Signal groups:
//   req_*      : per-requester valid/ready plus packed operand buses (slice i = [32*i +: 32])
//   fpu_*      : start/operands out to the shared add/sub core, done/data/status back
//   resp_*     : one-hot response valid to the owning requester, shared data/status/ready
//
// Modports:
//   master : the arbiter side (drives req_ready, fpu_start/op_a/op_b, resp_*)
//   slave  : the environment side (requesters plus the FPU core)
interface fpu_arbiter_if #(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_op_a;
  logic [32*N_REQ-1:0] req_op_b;

  logic                fpu_start;
  logic [31:0]         fpu_op_a;
  logic [31:0]         fpu_op_b;
  logic                fpu_done;
  logic [31:0]         fpu_data;
  logic [3:0]          fpu_status;

  logic [N_REQ-1:0]    resp_valid;
  logic [31:0]         resp_data;
  logic [3:0]          resp_status;
  logic                resp_ready;

  modport master (
    input  req_valid, req_op_a, req_op_b,
    input  fpu_done, fpu_data, fpu_status,
    input  resp_ready,
    output req_ready,
    output fpu_start, fpu_op_a, fpu_op_b,
    output resp_valid, resp_data, resp_status
  );

  modport slave (
    output req_valid, req_op_a, req_op_b,
    output fpu_done, fpu_data, fpu_status,
    output resp_ready,
    input  req_ready,
    input  fpu_start, fpu_op_a, fpu_op_b,
    input  resp_valid, resp_data, resp_status
  );

endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FPU add/sub core between N_REQ requesters.
//
// A round-robin grant is made in IDLE (req_ready is combinational in that cycle), the operand
// pair is registered towards the core, a one-cycle fpu_start is issued, and the arbiter waits
// for fpu_done with a TIMEOUT-cycle guard. The result (or a zero/4'b1111 timeout marker) is
// presented to the owner on resp_valid until resp_ready is seen.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : fpu_arbiter_if master modport (requester, core and response signals)
module fpu_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input logic           clock,
  input logic           reset,
  fpu_arbiter_if.master bus
);

  localparam int unsigned PtrW  = $clog2(N_REQ);
  localparam int unsigned Slots = 2 ** PtrW;
  localparam int unsigned CntW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRespond
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [PtrW-1:0]   owner_q;
  logic [CntW-1:0]   cnt_q;
  logic              fpu_start_q;
  logic [31:0]       fpu_op_a_q;
  logic [31:0]       fpu_op_b_q;
  logic [N_REQ-1:0]  resp_valid_q;
  logic [31:0]       resp_data_q;
  logic [3:0]        resp_status_q;

  // Requester signals padded to a power-of-two table so a PtrW-bit index is always in range.
  logic [31:0]       op_a_slot [Slots];
  logic [31:0]       op_b_slot [Slots];
  logic [Slots-1:0]  valid_slot;

  for (genvar s = 0; s < Slots; s++) begin : g_slot
    if (s < N_REQ) begin : g_used
      assign op_a_slot[s]  = bus.req_op_a[32*s +: 32];
      assign op_b_slot[s]  = bus.req_op_b[32*s +: 32];
      assign valid_slot[s] = bus.req_valid[s];
    end else begin : g_unused
      assign op_a_slot[s]  = '0;
      assign op_b_slot[s]  = '0;
      assign valid_slot[s] = 1'b0;
    end
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping modulo N_REQ.
  logic              grant_valid;
  logic [PtrW-1:0]   grant_idx;
  logic [PtrW:0]     scan_sum;
  logic [PtrW-1:0]   scan_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PtrW + 1)'(i);
      if (scan_sum >= (PtrW + 1)'(N_REQ)) begin
        scan_sum = scan_sum - (PtrW + 1)'(N_REQ);
      end
      scan_idx = scan_sum[PtrW-1:0];
      if (!grant_valid && valid_slot[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  logic [PtrW-1:0]   next_ptr;
  logic [N_REQ-1:0]  grant_oh;
  logic [N_REQ-1:0]  owner_oh;

  assign next_ptr = (grant_idx == PtrW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_oh = N_REQ'(1) << grant_idx;
  assign owner_oh = N_REQ'(1) << owner_q;

  // Gated by reset so the accept is withdrawn the moment reset asserts.
  assign bus.req_ready = (reset && (state_q == StIdle) && grant_valid) ? grant_oh : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      fpu_start_q   <= 1'b0;
      fpu_op_a_q    <= '0;
      fpu_op_b_q    <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            fpu_op_a_q  <= op_a_slot[grant_idx];
            fpu_op_b_q  <= op_b_slot[grant_idx];
            owner_q     <= grant_idx;
            rr_ptr_q    <= next_ptr;
            fpu_start_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          fpu_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          // Done takes priority over a timeout falling in the same cycle.
          if (bus.fpu_done) begin
            resp_data_q   <= bus.fpu_data;
            resp_status_q <= bus.fpu_status;
            resp_valid_q  <= owner_oh;
            state_q       <= StRespond;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            resp_data_q   <= '0;
            resp_status_q <= 4'b1111;
            resp_valid_q  <= owner_oh;
            state_q       <= StRespond;
          end
        end
        StRespond: begin
          if (bus.resp_ready) begin
            resp_valid_q <= '0;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.fpu_start   = fpu_start_q;
  assign bus.fpu_op_a    = fpu_op_a_q;
  assign bus.fpu_op_b    = fpu_op_b_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_status = resp_status_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: self-checking bench for fpu_arbiter with a stand-in FPU core.
// The stand-in core answers stub_delay cycles after start (0 = never) with op_a + op_b and
// status (op_a ^ op_b)[3:0], or a fixed value when stub_fixed_en is set.
module tb_fpu_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clock;
  logic reset;

  fpu_arbiter_if #(.N_REQ(N)) bus ();

  fpu_arbiter #(
    .N_REQ  (N),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks;
  int errors;
  int grant_log[$];

  logic [N-1:0] req_valid;
  logic [31:0]  op_a [N];
  logic [31:0]  op_b [N];
  logic         resp_ready;

  int           stub_delay;
  bit           stub_fixed_en;
  logic [31:0]  stub_fixed_data;
  logic         stub_done;
  logic [31:0]  stub_data;
  logic [3:0]   stub_status;
  logic         inj_done;
  logic [31:0]  inj_data;
  logic [3:0]   inj_status;

  assign bus.req_valid   = req_valid;
  assign bus.resp_ready  = resp_ready;
  assign bus.fpu_done    = stub_done | inj_done;
  assign bus.fpu_data    = inj_done ? inj_data : stub_data;
  assign bus.fpu_status  = inj_done ? inj_status : stub_status;

  for (genvar i = 0; i < N; i++) begin : g_ops
    assign bus.req_op_a[32*i +: 32] = op_a[i];
    assign bus.req_op_b[32*i +: 32] = op_b[i];
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] core_data(input logic [31:0] a, input logic [31:0] b);
    return stub_fixed_en ? stub_fixed_data : a + b;
  endfunction

  function automatic logic [3:0] core_status(input logic [31:0] a, input logic [31:0] b);
    return stub_fixed_en ? 4'h0 : (a[3:0] ^ b[3:0]);
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Stand-in core: sees start at the negedge, raises done stub_delay cycles later for one cycle.
  initial begin : stub_core
    logic [31:0] sa;
    logic [31:0] sb;
    stub_done   = 1'b0;
    stub_data   = '0;
    stub_status = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && bus.fpu_start === 1'b1 && stub_delay > 0) begin
        sa = bus.fpu_op_a;
        sb = bus.fpu_op_b;
        repeat (stub_delay) @(posedge clock);
        #1;
        stub_done   = 1'b1;
        stub_data   = core_data(sa, sb);
        stub_status = core_status(sa, sb);
        @(posedge clock);
        #1;
        stub_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    req_valid     = '0;
    resp_ready    = 1'b0;
    inj_done      = 1'b0;
    inj_data      = '0;
    inj_status    = '0;
    stub_delay    = 1;
    stub_fixed_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Per-cycle reference: an idle arbiter grants the first valid requester from its pointer,
  // start follows one cycle later, the response appears 2+delay cycles after the grant and
  // stays until resp_ready is seen.
  task automatic run_traffic(input string name, input logic [N-1:0] mask, input bit rnd,
                             input int cycles);
    int ptr, g, owner, start_at, resp_at;
    bit busy, hs;
    logic [N-1:0] exp_ready, exp_resp;
    logic [31:0]  exp_data;
    logic [3:0]   exp_status;
    ptr = 0; owner = 0; start_at = -1; resp_at = 0; busy = 1'b0;
    exp_data = '0; exp_status = '0;
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
    end
    req_valid = rnd ? '0 : mask;
    for (int cyc = 0; cyc < cycles + 12; cyc++) begin
      if (cyc >= cycles) begin
        req_valid = '0;
      end else if (rnd) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            op_a[i] = $urandom;
            op_b[i] = $urandom;
          end
        end
        resp_ready = 1'($urandom_range(0, 1));
        if (!busy) stub_delay = $urandom_range(1, 6);
      end
      @(negedge clock);
      exp_ready = '0;
      g = -1;
      if (!busy && req_valid != '0) begin
        g = pick(req_valid, ptr);
        exp_ready[g] = 1'b1;
      end
      exp_resp = '0;
      if (busy && cyc >= resp_at) exp_resp[owner] = 1'b1;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++;
        $display("FAIL %s_req_ready cycle %0d: got %b want %b", name, cyc, bus.req_ready,
                 exp_ready);
      end
      checks++;
      if (bus.fpu_start !== (busy && cyc == start_at)) begin
        errors++;
        $display("FAIL %s_fpu_start cycle %0d: got %b want %b", name, cyc, bus.fpu_start,
                 (busy && cyc == start_at));
      end
      checks++;
      if (bus.resp_valid !== exp_resp) begin
        errors++;
        $display("FAIL %s_resp_valid cycle %0d: got %b want %b", name, cyc, bus.resp_valid,
                 exp_resp);
      end
      if (exp_resp != '0) begin
        checks++;
        if (bus.resp_data !== exp_data || bus.resp_status !== exp_status) begin
          errors++;
          $display("FAIL %s_resp_payload cycle %0d: got %h/%h want %h/%h", name, cyc,
                   bus.resp_data, bus.resp_status, exp_data, exp_status);
        end
      end
      hs = busy && cyc >= resp_at && resp_ready;
      tick();
      if (hs) busy = 1'b0;
      if (g >= 0) begin
        busy       = 1'b1;
        owner      = g;
        start_at   = cyc + 1;
        resp_at    = cyc + 2 + stub_delay;
        exp_data   = core_data(op_a[g], op_b[g]);
        exp_status = core_status(op_a[g], op_b[g]);
        ptr        = (g + 1) % N;
        grant_log.push_back(g);
        if (rnd) begin
          req_valid[g] = 1'b0;
        end else begin
          op_a[g] = $urandom;
          op_b[g] = $urandom;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    resp_ready = 1'b0;
    inj_done  = 1'b0;
    stub_delay = 1;
    stub_fixed_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.req_ready !== '0 || bus.fpu_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b start=%b want 0000/0", bus.req_ready, bus.fpu_start);
    end
    checks++;
    if (bus.fpu_op_a !== '0 || bus.fpu_op_b !== '0) begin
      errors++;
      $display("FAIL reset_ops: got %h/%h want 0/0", bus.fpu_op_a, bus.fpu_op_b);
    end
    checks++;
    if (bus.resp_valid !== '0 || bus.resp_data !== '0 || bus.resp_status !== '0) begin
      errors++;
      $display("FAIL reset_resp: got %b/%h/%h want 0", bus.resp_valid, bus.resp_data,
               bus.resp_status);
    end
  endtask

  task automatic test_single();
    do_reset();
    stub_fixed_en   = 1'b1;
    stub_fixed_data = 32'h4000_0000;
    stub_delay      = 1;
    resp_ready      = 1'b1;
    op_a[0] = 32'h3E00_0000;
    op_b[0] = 32'h3E00_0000;
    req_valid = 4'b0001;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready_c0: got %b want 0001", bus.req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (bus.fpu_start !== 1'b1 || bus.fpu_op_a !== 32'h3E00_0000 ||
        bus.fpu_op_b !== 32'h3E00_0000) begin
      errors++;
      $display("FAIL single_start_c1: got start=%b a=%h b=%h want 1/3e000000/3e000000",
               bus.fpu_start, bus.fpu_op_a, bus.fpu_op_b);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.fpu_start !== 1'b0 || bus.resp_valid !== '0) begin
      errors++;
      $display("FAIL single_c2: got start=%b resp_valid=%b want 0/0000", bus.fpu_start,
               bus.resp_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_data !== 32'h4000_0000 ||
        bus.resp_status !== 4'h0) begin
      errors++;
      $display("FAIL single_resp_c3: got %b/%h/%h want 0001/40000000/0", bus.resp_valid,
               bus.resp_data, bus.resp_status);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== '0) begin
      errors++;
      $display("FAIL single_c4: got resp_valid=%b want 0000", bus.resp_valid);
    end
    stub_fixed_en = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    do_reset();
    resp_ready = 1'b1;
    stub_delay = 1;
    run_traffic("rr", 4'b1111, 1'b0, 18);
    checks++;
    if (grant_log.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants want 5", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[i] != exp_seq[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_pointer_wrap();
    int exp_seq[3];
    exp_seq = '{1, 3, 1};
    do_reset();
    resp_ready = 1'b1;
    stub_delay = 1;
    run_traffic("wrap", 4'b1010, 1'b0, 10);
    checks++;
    if (grant_log.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d grants want 3", grant_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (grant_log[i] != exp_seq[i]) begin
          errors++;
          $display("FAIL wrap_order[%0d]: got %0d want %0d", i, grant_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a, b;
    bit bad;
    do_reset();
    stub_delay = 0;
    resp_ready = 1'b1;
    op_a[1] = $urandom;
    op_b[1] = $urandom;
    req_valid = 4'b0010;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_grant: got %b want 0010", bus.req_ready);
    end
    tick();
    req_valid = '0;
    bad = 1'b0;
    for (int c = 1; c < 18; c++) begin
      @(negedge clock);
      if (bus.resp_valid !== '0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL timeout_early: got response before cycle 18 want none");
    end
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 4'b0010 || bus.resp_data !== '0 || bus.resp_status !== 4'b1111) begin
      errors++;
      $display("FAIL timeout_resp_c18: got %b/%h/%h want 0010/00000000/f", bus.resp_valid,
               bus.resp_data, bus.resp_status);
    end
    repeat (5) tick();
    inj_data   = 32'hDEAD_BEEF;
    inj_status = 4'h5;
    inj_done   = 1'b1;
    tick();
    inj_done = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (bus.resp_valid !== '0 || bus.fpu_start !== 1'b0 || bus.req_ready !== '0 ||
          bus.resp_data !== '0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL timeout_late_done: got activity after late done want none");
    end
    a = $urandom;
    b = $urandom;
    op_a[2] = a;
    op_b[2] = b;
    stub_delay = 1;
    req_valid = 4'b0100;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_next_grant: got %b want 0100", bus.req_ready);
    end
    tick();
    req_valid = '0;
    repeat (2) tick();
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_data !== core_data(a, b) ||
        bus.resp_status !== core_status(a, b)) begin
      errors++;
      $display("FAIL timeout_next_resp: got %b/%h/%h want 0100/%h/%h", bus.resp_valid,
               bus.resp_data, bus.resp_status, core_data(a, b), core_status(a, b));
    end
    tick();
  endtask

  task automatic test_done_at_timeout();
    logic [31:0] a, b;
    do_reset();
    stub_delay = TO;
    resp_ready = 1'b1;
    a = $urandom;
    b = $urandom;
    op_a[3] = a;
    op_b[3] = b;
    req_valid = 4'b1000;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL done_wins_grant: got %b want 1000", bus.req_ready);
    end
    tick();
    req_valid = '0;
    repeat (17) tick();
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 4'b1000 || bus.resp_data !== core_data(a, b) ||
        bus.resp_status !== core_status(a, b)) begin
      errors++;
      $display("FAIL done_wins_resp: got %b/%h/%h want 1000/%h/%h", bus.resp_valid,
               bus.resp_data, bus.resp_status, core_data(a, b), core_status(a, b));
    end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] a, b, c, d;
    bit bad;
    do_reset();
    stub_delay = 1;
    resp_ready = 1'b0;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    op_a[0] = a;
    op_b[0] = b;
    req_valid = 4'b0001;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_grant0: got %b want 0001", bus.req_ready);
    end
    tick();
    req_valid = '0;
    repeat (2) tick();
    op_a[2] = c;
    op_b[2] = d;
    req_valid = 4'b0100;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.resp_valid !== 4'b0001 || bus.resp_data !== core_data(a, b) ||
          bus.resp_status !== core_status(a, b) || bus.req_ready !== '0 ||
          bus.fpu_start !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got unstable response or grant while stalled want stable/none");
    end
    resp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 4'b0001 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL bp_release: got resp_valid=%b ready=%b want 0001/0000", bus.resp_valid,
               bus.req_ready);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.resp_valid !== '0) begin
      errors++;
      $display("FAIL bp_grant2: got ready=%b resp_valid=%b want 0100/0000", bus.req_ready,
               bus.resp_valid);
    end
    tick();
    req_valid = '0;
    repeat (2) tick();
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_data !== core_data(c, d)) begin
      errors++;
      $display("FAIL bp_resp2: got %b/%h want 0100/%h", bus.resp_valid, bus.resp_data,
               core_data(c, d));
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit bad;
    do_reset();
    stub_delay = 1;
    resp_ready = 1'b1;
    op_a[3] = $urandom | 32'h1;
    op_b[3] = $urandom;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (3) tick();
    op_a[0] = $urandom | 32'h8000_0000;
    op_b[0] = $urandom | 32'h1;
    stub_delay = 0;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (2) tick();
    #2;
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== '0 || bus.fpu_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got ready=%b start=%b want 0000/0", bus.req_ready,
               bus.fpu_start);
    end
    checks++;
    if (bus.fpu_op_a !== '0 || bus.fpu_op_b !== '0) begin
      errors++;
      $display("FAIL midrst_ops: got %h/%h want 0/0", bus.fpu_op_a, bus.fpu_op_b);
    end
    checks++;
    if (bus.resp_valid !== '0 || bus.resp_data !== '0 || bus.resp_status !== '0) begin
      errors++;
      $display("FAIL midrst_resp: got %b/%h/%h want 0", bus.resp_valid, bus.resp_data,
               bus.resp_status);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid = '0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus.resp_valid !== '0 || bus.fpu_start !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_quiet: got resp_valid or fpu_start after release want none");
    end
    stub_delay = 1;
    req_valid = 4'b1111;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr: got %b want 0001", bus.req_ready);
    end
    tick();
    req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_random_traffic();
    do_reset();
    run_traffic("rand", '0, 1'b1, 400);
    checks++;
    if (grant_log.size() < 20) begin
      errors++;
      $display("FAIL rand_progress: got %0d grants want at least 20", grant_log.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_done_at_timeout();
    test_back_pressure();
    test_reset_mid_op();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
